mv_operand_loader: RTL and testbench

- Write-side front end for the 4-row matrix-vector systolic array.
- Accepts a serial stream of WIDTH-bit operand words under a valid/ready handshake and assembles them into the M1..M4 row buses and the V vector bus.
- Once all operands are loaded, drives the array enable `en` high for a fixed run window, pulses `done`, then accepts the next operand set.

---
 rtl/mv_operand_loader_pkg.sv | 28 ++
 rtl/mv_operand_regfile.sv | 55 +++++
 rtl/mv_operand_loader.sv | 123 ++++++++++++
 tb/tb_mv_operand_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mv_operand_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mv_operand_loader_pkg
// Purpose  : Shared state encoding, set geometry and slice helper for the
//            matrix-vector operand loader.
// Revision : 1.0
// ============================================================================
package mv_operand_loader_pkg;

   localparam int c_DIMENSION     = 4;
   localparam int c_NUM_BUSES     = c_DIMENSION + 1;
   localparam int c_WORDS_PER_SET = c_DIMENSION * (c_DIMENSION + 1);
   localparam int c_WORD_CNT_W    = 5;
   localparam int c_RUN_CNT_W     = 8;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Low bit of element idx inside a packed bus; the array uses the same packing.
   function automatic int elem_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mv_operand_regfile.sv
`default_nettype none
// ============================================================================
// Module   : mv_operand_regfile
// Purpose  : Word-addressed write-only register file holding M1..M4 and V.
// Revision : 1.0
// ============================================================================
module mv_operand_regfile
   import mv_operand_loader_pkg::*;
#(
   parameter int DIMENSION = 4,
   parameter int WIDTH     = 8
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [c_WORD_CNT_W-1:0]    waddr,
   input  logic [WIDTH-1:0]           wdata,
   output logic [DIMENSION*WIDTH-1:0] m1,
   output logic [DIMENSION*WIDTH-1:0] m2,
   output logic [DIMENSION*WIDTH-1:0] m3,
   output logic [DIMENSION*WIDTH-1:0] m4,
   output logic [DIMENSION*WIDTH-1:0] v
);

   localparam int c_NUM_ELEMS = c_NUM_BUSES * DIMENSION;

   logic [c_NUM_ELEMS-1:0][WIDTH-1:0]       r_elem;
   logic [c_NUM_BUSES-1:0][DIMENSION*WIDTH-1:0] w_bus;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_elem <= '0;
      end else if (we) begin
         for (int i = 0; i < c_NUM_ELEMS; i++) begin
            if (waddr == c_WORD_CNT_W'(i)) begin
               r_elem[i] <= wdata;
            end
         end
      end
   end

   for (genvar b = 0; b < c_NUM_BUSES; b++) begin : g_bus
      for (genvar e = 0; e < DIMENSION; e++) begin : g_elem
         assign w_bus[b][elem_lsb(e, WIDTH) +: WIDTH] = r_elem[b*DIMENSION + e];
      end
   end

   assign m1 = w_bus[0];
   assign m2 = w_bus[1];
   assign m3 = w_bus[2];
   assign m4 = w_bus[3];
   assign v  = w_bus[4];

endmodule
`default_nettype wire

// File: rtl/mv_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : mv_operand_loader
// Purpose  : Serial operand loader and run sequencer for the 4-row systolic array.
// Revision : 1.0
// ============================================================================
module mv_operand_loader
   import mv_operand_loader_pkg::*;
#(
   parameter int DIMENSION  = 4,
   parameter int WIDTH      = 8,
   parameter int RUN_CYCLES = 8
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [DIMENSION*WIDTH-1:0] M1,
   output logic [DIMENSION*WIDTH-1:0] M2,
   output logic [DIMENSION*WIDTH-1:0] M3,
   output logic [DIMENSION*WIDTH-1:0] M4,
   output logic [DIMENSION*WIDTH-1:0] V,
   output logic                       en,
   output logic                       busy,
   output logic                       done
);

   localparam logic [c_WORD_CNT_W-1:0] c_LAST_WORD = c_WORD_CNT_W'(c_WORDS_PER_SET - 1);
   localparam logic [c_RUN_CNT_W-1:0]  c_RUN_LAST  = c_RUN_CNT_W'(RUN_CYCLES - 1);

   state_t                  r_state, w_state_nxt;
   logic [c_WORD_CNT_W-1:0] r_word_cnt, w_word_cnt_nxt;
   logic [c_RUN_CNT_W-1:0]  r_run_cnt, w_run_cnt_nxt;
   logic                    r_en, w_en_nxt;
   logic                    r_done, w_done_nxt;
   logic                    w_accept;

   assign in_ready = (r_state == LOAD);
   assign busy     = (r_state == RUN) || (r_state == DONE);
   assign w_accept = in_valid & in_ready & ~clear;
   assign en       = r_en;
   assign done     = r_done;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= LOAD;
         r_word_cnt <= '0;
         r_run_cnt  <= '0;
         r_en       <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_word_cnt <= w_word_cnt_nxt;
         r_run_cnt  <= w_run_cnt_nxt;
         r_en       <= w_en_nxt;
         r_done     <= w_done_nxt;
      end
   end

   // en is the registered image of "next state is RUN" so it never glitches.
   always_comb begin
      w_state_nxt    = r_state;
      w_word_cnt_nxt = r_word_cnt;
      w_run_cnt_nxt  = r_run_cnt;
      w_en_nxt       = 1'b0;
      w_done_nxt     = 1'b0;
      if (clear) begin
         w_state_nxt    = LOAD;
         w_word_cnt_nxt = '0;
         w_run_cnt_nxt  = '0;
      end else begin
         case (r_state)
            LOAD: begin
               if (w_accept) begin
                  if (r_word_cnt == c_LAST_WORD) begin
                     w_word_cnt_nxt = '0;
                     w_state_nxt    = RUN;
                     w_en_nxt       = 1'b1;
                  end else begin
                     w_word_cnt_nxt = r_word_cnt + 1'b1;
                  end
               end
            end
            RUN: begin
               if (r_run_cnt == c_RUN_LAST) begin
                  w_run_cnt_nxt = '0;
                  w_state_nxt   = DONE;
                  w_done_nxt    = 1'b1;
               end else begin
                  w_run_cnt_nxt = r_run_cnt + 1'b1;
                  w_en_nxt      = 1'b1;
               end
            end
            DONE: begin
               w_state_nxt = LOAD;
            end
            default: begin
               w_state_nxt = LOAD;
            end
         endcase
      end
   end

   mv_operand_regfile #(
      .DIMENSION (DIMENSION),
      .WIDTH     (WIDTH)
   ) u_regfile (
      .clk   (clk),
      .rst   (rst),
      .we    (w_accept),
      .waddr (r_word_cnt),
      .wdata (in_data),
      .m1    (M1),
      .m2    (M2),
      .m3    (M3),
      .m4    (M4),
      .v     (V)
   );

endmodule
`default_nettype wire

// File: tb/tb_mv_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mv_operand_loader
// Purpose  : Self-checking directed bench for mv_operand_loader.
// Revision : 1.0
// ============================================================================
module tb_mv_operand_loader;

   logic        clk = 1'b0;
   logic        rst, clear, in_valid;
   logic [7:0]  in_data;
   logic        in_ready, en, busy, done;
   logic [31:0] M1, M2, M3, M4, V;
   logic        in_ready1, en1, busy1, done1;
   logic [31:0] M1_1, M2_1, M3_1, M4_1, V_1;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mv_operand_loader #(.DIMENSION(4), .WIDTH(8), .RUN_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .M1(M1), .M2(M2), .M3(M3), .M4(M4), .V(V),
      .en(en), .busy(busy), .done(done)
   );

   mv_operand_loader #(.DIMENSION(4), .WIDTH(8), .RUN_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready1), .M1(M1_1), .M2(M2_1), .M3(M3_1), .M4(M4_1), .V(V_1),
      .en(en1), .busy(busy1), .done(done1)
   );

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic [3:0] exp;   // {in_ready, en, done, busy} after the edge
   } vec_t;

   vec_t vt[29];

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_bus(input logic [7:0] base, input int b);
      logic [31:0] r;
      for (int e = 0; e < 4; e++) r[8*e +: 8] = base + 8'(4*b + e + 1);
      return r;
   endfunction

   function automatic logic [159:0] exp_all(input logic [7:0] base);
      return {exp_bus(base, 4), exp_bus(base, 3), exp_bus(base, 2), exp_bus(base, 1), exp_bus(base, 0)};
   endfunction

   function automatic logic [159:0] act_all();
      return {V, M4, M3, M2, M1};
   endfunction

   function automatic logic [3:0] flags();
      return {in_ready, en, done, busy};
   endfunction

   task automatic send_word(input logic [7:0] d);
      int n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) chk("send_word_timeout", 0, 1);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic load_set(input logic [7:0] base, input bit gap);
      for (int k = 1; k <= 20; k++) begin
         send_word(base + 8'(k));
         if (gap && k < 20) tick();
      end
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      int en_cnt = 0;
      while (!done && n < 40) begin
         if (en) en_cnt++;
         tick();
         n++;
      end
      chk({name, "_en_cycles"}, 160'(en_cnt), 160'd8);
      chk({name, "_done_seen"}, 160'(done), 160'd1);
      tick();
      chk({name, "_back_to_load"}, 160'(flags()), 160'(4'b1000));
   endtask

   task automatic quiet_window(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (en || done) seen = 1'b1;
         tick();
      end
      chk(name, 160'(seen), 160'd0);
   endtask

   initial begin
      int en1_cnt, done1_cnt, c0;

      for (int k = 0; k < 20; k++) vt[k] = '{1'b1, 8'(k + 1), (k == 19) ? 4'b0101 : 4'b1000};
      for (int k = 20; k < 27; k++) vt[k] = '{1'b1, 8'hFF, 4'b0101};
      vt[27] = '{1'b1, 8'hFF, 4'b0011};
      vt[28] = '{1'b1, 8'hFF, 4'b1000};

      rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
      tick();
      chk("reset_flags", 160'(flags()), 160'(4'b1000));
      chk("reset_buses", act_all(), 160'd0);
      tick();
      rst = 1'b1;

      // Contiguous set followed by backpressure during RUN/DONE
      en1_cnt = 0; done1_cnt = 0;
      for (int k = 0; k < 29; k++) begin
         in_valid = vt[k].v;
         in_data  = vt[k].d;
         tick();
         chk($sformatf("vec%0d_flags", k), 160'(flags()), 160'(vt[k].exp));
         if (k >= 19) begin
            if (en1) en1_cnt++;
            if (done1) done1_cnt++;
         end
      end
      in_valid = 1'b0;
      chk("set1_M1", 160'(M1), 160'(32'h04030201));
      chk("set1_M4", 160'(M4), 160'(32'h100F0E0D));
      chk("set1_V",  160'(V),  160'(32'h14131211));
      chk("set1_all", act_all(), exp_all(8'h00));
      chk("rc1_en_cycles", 160'(en1_cnt), 160'd1);
      chk("rc1_done_pulses", 160'(done1_cnt), 160'd1);

      // Second set after backpressure
      load_set(8'h20, 1'b0);
      chk("set2_en_start", 160'(en), 160'd1);
      chk("set2_buses", act_all(), exp_all(8'h20));
      wait_done("set2");

      // Gapped source
      c0 = cyc;
      load_set(8'h00, 1'b1);
      chk("gap_latency", 160'(cyc - c0), 160'd39);
      chk("gap_en_start", 160'(en), 160'd1);
      chk("gap_buses", act_all(), exp_all(8'h00));
      wait_done("gap");

      // clear after 10 words
      for (int k = 1; k <= 10; k++) send_word(8'hA0 + 8'(k));
      clear = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
      tick();
      clear = 1'b0; in_valid = 1'b0;
      chk("clr10_flags", 160'(flags()), 160'(4'b1000));
      load_set(8'h50, 1'b0);
      chk("clr10_en_after_20", 160'(en), 160'd1);
      chk("clr10_buses", act_all(), exp_all(8'h50));
      wait_done("clr10");

      // clear on the 4th RUN cycle
      load_set(8'h60, 1'b0);
      tick(); tick(); tick();
      chk("clr_run4_en_before", 160'(en), 160'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_run_flags", 160'(flags()), 160'(4'b1000));
      chk("clr_run_buses", act_all(), exp_all(8'h60));
      quiet_window("clr_run_no_done");

      // clear while done is high
      load_set(8'h70, 1'b0);
      begin
         int n = 0;
         while (!done && n < 40) begin tick(); n++; end
      end
      chk("clr_done_seen", 160'(done), 160'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_done_flags", 160'(flags()), 160'(4'b1000));

      // reset mid-RUN
      load_set(8'h90, 1'b0);
      tick(); tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("rst_run_flags", 160'(flags()), 160'(4'b1000));
      chk("rst_run_buses", act_all(), 160'd0);
      quiet_window("rst_run_no_done");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
